// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings for the unified memory port arbiter
package mem_arb_pkg;

  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;

  // Wide enough for any starvation limit in 1..15
  localparam int CNT_W = 4;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - winner select with bounded fetch starvation
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic if_req,
  input  logic dm_req,
  input  logic grant_evt,
  output logic grant_if,
  output logic grant_dm
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_q;

  // Data side normally wins; fetch wins once it has been passed over LIMIT times
  always_comb begin
    grant_if = if_req && (!dm_req || (starve_cnt_q == LIMIT));
    grant_dm = dm_req && !grant_if;
  end

  // Count data grants made while fetch waits; clear on fetch grant or when fetch is idle
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      starve_cnt_q <= '0;
    end else if (grant_evt) begin
      if (grant_if || !if_req) begin
        starve_cnt_q <= '0;
      end else if (grant_dm && (starve_cnt_q != LIMIT)) begin
        starve_cnt_q <= starve_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and data access
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_DEPTH    = 513,
  parameter int STARVE_LIMIT = 4,
  parameter int AW           = AW_DEF,
  parameter int DW           = DW_DEF
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  output logic          if_err,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_ack,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_err,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  // Full-width bound so high address bits are never silently dropped
  localparam logic [AW-1:0] DEPTH_W = AW'(MEM_DEPTH);

  state_e        state_q;
  owner_e        owner_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          we_q;
  logic          if_ack_q, if_err_q, dm_ack_q, dm_err_q;
  logic [DW-1:0] if_rdata_q, dm_rdata_q;

  logic grant_if, grant_dm, grant_evt, in_range;

  assign grant_evt = (state_q == ST_IDLE);
  assign in_range  = (addr_q < DEPTH_W);

  mem_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .Clk      (Clk),
    .Reset    (Reset),
    .if_req   (if_req),
    .dm_req   (dm_req),
    .grant_evt(grant_evt),
    .grant_if (grant_if),
    .grant_dm (grant_dm)
  );

  // Two-state access sequencer: latch the winner, run one access, register the response
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_NONE;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      if_ack_q   <= 1'b0;
      if_err_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
      dm_err_q   <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      // Acks and their qualifiers are single-cycle pulses
      if_ack_q <= 1'b0;
      if_err_q <= 1'b0;
      dm_ack_q <= 1'b0;
      dm_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_if) begin
            addr_q  <= if_addr;
            wdata_q <= '0;
            we_q    <= 1'b0;
            owner_q <= OWN_IF;
            state_q <= ST_ACCESS;
          end else if (grant_dm) begin
            addr_q  <= dm_addr;
            wdata_q <= dm_wdata;
            we_q    <= dm_we;
            owner_q <= OWN_DM;
            state_q <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // Read data sampled here is the pre-write contents for stores
          case (owner_q)
            OWN_IF: begin
              if_ack_q   <= 1'b1;
              if_err_q   <= !in_range;
              if_rdata_q <= in_range ? mem_rdata : '0;
            end
            OWN_DM: begin
              dm_ack_q   <= 1'b1;
              dm_err_q   <= !in_range;
              dm_rdata_q <= in_range ? mem_rdata : '0;
            end
            default: ;
          endcase
          owner_q <= OWN_NONE;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign if_ack    = if_ack_q;
  assign if_err    = if_err_q;
  assign if_rdata  = if_rdata_q;
  assign dm_ack    = dm_ack_q;
  assign dm_err    = dm_err_q;
  assign dm_rdata  = dm_rdata_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  // Derived from state so an asynchronous reset removes the write at once
  assign mem_we    = (state_q == ST_ACCESS) && we_q && in_range;
  assign busy      = (state_q == ST_ACCESS);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for the memory port arbiter
module tb_mem_port_arbiter;

  localparam int DEPTH = 513;

  logic        Clk, Reset;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic        if_ack, if_err, dm_ack, dm_err, mem_we, busy;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;

  mem_port_arbiter dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_ack   (if_ack),
    .if_rdata (if_rdata),
    .if_err   (if_err),
    .dm_req   (dm_req),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_ack   (dm_ack),
    .dm_rdata (dm_rdata),
    .dm_err   (dm_err),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_rdata(mem_rdata),
    .busy     (busy)
  );

  typedef struct {
    logic        is_dm;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem     [0:DEPTH-1];
  logic [31:0] ref_mem [0:DEPTH-1];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          we_cnt = 0;
  logic [31:0] we_addr = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // Memory: combinational read (garbage beyond range), write on rising edge
  always_comb begin
    if (mem_addr < DEPTH) mem_rdata = mem[mem_addr[9:0]];
    else                  mem_rdata = 32'hDEAD_BEEF;
  end
  always @(posedge Clk) if (mem_we && mem_addr < DEPTH) mem[mem_addr[9:0]] <= mem_wdata;

  always @(negedge Clk) if (mem_we) begin we_cnt++; we_addr = mem_addr; end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Response monitor: every ack must match the head of the scoreboard
  always @(negedge Clk) begin
    if (if_ack === 1'b1 || dm_ack === 1'b1) begin
      exp_t e;
      chk("ack_exclusive", {31'd0, if_ack & dm_ack}, 32'd0);
      checks++;
      assert (sb.size() > 0) else begin
        failures++;
        $error("FAIL unexpected_ack observed=if%0b/dm%0b expected=none", if_ack, dm_ack);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("ack_owner", {31'd0, dm_ack}, {31'd0, e.is_dm});
        chk("rdata", e.is_dm ? dm_rdata : if_rdata, e.rdata);
        chk("err", {31'd0, e.is_dm ? dm_err : if_err}, {31'd0, e.err});
        if (e.cyc >= 0) chk("ack_cycle", cyc, e.cyc);
      end
    end
  end

  function automatic logic [31:0] ref_val(input logic [31:0] a);
    return (a < DEPTH) ? ref_mem[a[9:0]] : 32'd0;
  endfunction

  task automatic push(input logic is_dm, input logic [31:0] a, input int c);
    exp_t e;
    e.is_dm = is_dm;
    e.rdata = ref_val(a);
    e.err   = !(a < DEPTH);
    e.cyc   = c;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Wait until every expected ack has been seen; stop just after the last ack edge
  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge Clk);
      #1;
      if (sb.size() == 0) return;
    end
    checks++;
    failures++;
    $error("FAIL drain_timeout observed=%0d expected=0", sb.size());
    sb.delete();
  endtask

  task automatic single_if(input logic [31:0] a);
    step();
    if_req = 1'b1; if_addr = a;
    push(1'b0, a, cyc + 2);
    step();
    if_req = 1'b0; if_addr = 32'hFFFF_FFFF;
    drain(10);
  endtask

  task automatic single_dm(input logic we, input logic [31:0] a, input logic [31:0] d);
    step();
    dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = d;
    push(1'b1, a, cyc + 2);
    if (we && a < DEPTH) ref_mem[a[9:0]] = d;
    step();
    dm_req = 1'b0; dm_we = 1'b1; dm_addr = 32'd7; dm_wdata = 32'hBAD0_BAD0;
    drain(10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, k;
    Reset = 1'b1;
    if_req = 0; dm_req = 0; dm_we = 0;
    if_addr = 0; dm_addr = 0; dm_wdata = 0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h1000_0000 + i;
    ref_mem[128] = 32'h8c03_0000;
    ref_mem[2]   = 32'h0000_0001;
    ref_mem[6]   = 32'h0000_0066;
    ref_mem[10]  = 32'hAAAA_0010;
    ref_mem[20]  = 32'hBBBB_0020;
    for (int i = 0; i < DEPTH; i++) mem[i] <= ref_mem[i];

    #3;
    chk("rst_acks", {28'd0, if_ack, dm_ack, if_err, dm_err}, 32'd0);
    chk("rst_we_busy", {30'd0, mem_we, busy}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rdata", if_rdata | dm_rdata, 32'd0);
    repeat (3) step();
    Reset = 1'b0;
    step();

    // Single fetch of preloaded word 128
    single_if(32'd128);

    // Store then load back word 6
    w0 = we_cnt;
    single_dm(1'b1, 32'd6, 32'h0000_000D);
    chk("store_we_pulses", we_cnt - w0, 32'd1);
    chk("store_we_addr", we_addr, 32'd6);
    chk("store_mem_word", mem[6], 32'h0000_000D);
    single_dm(1'b0, 32'd6, 32'h0);

    // Range boundaries: last valid word, first invalid, high bits set
    w0 = we_cnt;
    single_dm(1'b1, 32'd513, 32'h1234_5678);
    chk("oor_store_no_we", we_cnt - w0, 32'd0);
    single_dm(1'b0, 32'd512, 32'h0);
    single_dm(1'b0, 32'h8000_0006, 32'h0);
    single_if(32'h0000_0201);

    // Held fetch request alone: ack every second cycle
    step();
    k = cyc;
    if_req = 1'b1; if_addr = 32'd128;
    for (int j = 0; j < 4; j++) push(1'b0, 32'd128, k + 2 + 2 * j);
    drain(20);
    if_req = 1'b0;
    step();

    // Both held: four data grants then one fetch grant, repeating
    k = cyc;
    if_req = 1'b1; if_addr = 32'd10;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'd20;
    for (int j = 0; j < 10; j++)
      push((j % 5) != 4, ((j % 5) != 4) ? 32'd20 : 32'd10, k + 2 + 2 * j);
    drain(40);
    if_req = 1'b0; dm_req = 1'b0;
    step();

    // Reset during a store access aborts it
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'd2; dm_wdata = 32'h0000_0099;
    step();
    dm_req = 1'b0;
    chk("abort_we_before", {31'd0, mem_we}, 32'd1);
    #2;
    Reset = 1'b1;
    #1;
    chk("abort_we_after", {31'd0, mem_we}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    repeat (2) step();
    Reset = 1'b0;
    repeat (3) step();
    chk("abort_word2", mem[2], 32'h0000_0001);
    chk("sb_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified instruction/data memory between two requesters: instruction fetch (IF) and data load/store (DM).
- The memory has a combinational read and a write that commits on the rising Clk edge.
- The arbiter registers the winning request, drives the memory port for exactly one access cycle, then returns read data with a one-cycle ack pulse.
- It sits between the multicycle control/datapath and the Memory block.

Parameters:
- MEM_DEPTH, 513: number of valid memory words. Addresses >= MEM_DEPTH are out of range.
- STARVE_LIMIT, 4: maximum number of consecutive DM grants while IF is pending. Range 1..15.
- AW, 32: address width.
- DW, 32: data width.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; level signal.
- if_addr  in  AW  fetch word address. Indexes memory words directly; no byte shift.
- if_ack  out  1  one-cycle pulse: fetch access complete.
- if_rdata  out  DW  fetch read data; valid while if_ack=1.
- if_err  out  1  qualifies if_ack: address was out of range.
- dm_req  in  1  data request; level signal.
- dm_we  in  1  1=store, 0=load.
- dm_addr  in  AW  data word address.
- dm_wdata  in  DW  store data.
- dm_ack  out  1  one-cycle pulse: data access complete.
- dm_rdata  out  DW  load data; valid while dm_ack=1.
- dm_err  out  1  qualifies dm_ack: address was out of range.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_we  out  1  memory write enable.
- mem_rdata  in  DW  memory combinational read data.
- busy  out  1  high while the state is ACCESS.

Behaviour:
- Reset values (asynchronous, effective immediately):
  - state=IDLE, owner=NONE.
  - All acks, errs, mem_we and busy = 0.
  - mem_addr, mem_wdata, if_rdata, dm_rdata = 0.
  - Starvation count = 0.
- Reset asserted during ACCESS aborts the access. mem_we drops with no clock edge, so no write commits and no ack is issued.
- States: IDLE and ACCESS.
- IDLE:
  - Requests are sampled at the rising edge.
  - If any request is present: latch the winner's addr, wdata and we (we forced 0 for IF); set owner; go to ACCESS.
  - If no request is present: stay in IDLE.
- Arbitration, when both requests are high:
  - DM wins unless starve_cnt == STARVE_LIMIT, in which case IF wins.
  - starve_cnt increments on each DM grant made while if_req=1, saturating at STARVE_LIMIT.
  - starve_cnt clears on any IF grant, and on any IDLE cycle where if_req=0.
- ACCESS (exactly one cycle):
  - mem_addr/mem_wdata come from latched registers.
  - mem_we = latched_we AND in_range.
  - At the rising edge:
    - Write commits in memory.
    - Owner's rdata register <= mem_rdata, or 0 if out of range.
    - Owner's ack <= 1; owner's err <= NOT in_range.
    - state -> IDLE.
- Ack cycle: ack/err are high for one cycle, concurrent with the IDLE cycle. Requests are sampled in that same cycle.
- A requester that still holds req during its ack cycle issues a new request. Requesters drop req combinationally on ack to avoid a repeat.
- Latency: 2 cycles from the req-sampling edge to ack. Sustained throughput is 1 access per 2 cycles.
- rdata registers hold their value until the next ack for the same requester.
- Store acks: rdata = value read at the address before the write (read-before-write).
- Address stability: addr/wdata/we need only be stable at the sampling edge. Changes during ACCESS are ignored.
- Range check: in_range = (latched_addr < MEM_DEPTH), compared on the full AW bits with no truncation.

Decomposition:
- Shared package mem_arb_pkg:
  - State encoding: IDLE=1'b0, ACCESS=1'b1.
  - Owner encoding: NONE=2'd0, IF=2'd1, DM=2'd2.
  - AW/DW defaults.
- One sub-module, mem_arb_pick:
  - Combinational winner select plus the registered starve_cnt.
  - Inputs: Clk, Reset, if_req, dm_req, grant_evt.
  - Outputs: grant_if, grant_dm.

Test Plan:
- Reset held, then released; memory word 128 preloaded = 32'h8c030000; if_req=1, if_addr=128 for one cycle -> 2 cycles later if_ack=1 for 1 cycle with if_rdata=32'h8c030000, if_err=0; no other ack.
- dm store: addr=6, wdata=32'h0000000D -> mem_we=1 for exactly 1 cycle with mem_addr=6; a following dm load of addr 6 -> dm_rdata=32'h0000000D.
- if_req and dm_req held continuously, STARVE_LIMIT=4 -> grant order DM,DM,DM,DM,IF repeating; each ack separated by 1 IDLE cycle.
- dm store to addr=513 -> mem_we stays 0, dm_ack=1 with dm_err=1, dm_rdata=0; memory contents unchanged.
- Reset asserted mid-ACCESS of a store to addr 2 -> mem_we falls immediately; word 2 retains its old value 1; no ack; busy=0.
- if_req held through its ack cycle, dm_req=0 -> back-to-back IF acks every 2 cycles; starve_cnt remains 0.
